// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// data width and the bit-time helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Clock cycles per serial bit, truncated toward zero.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO used as the transmit queue. DEPTH must be a power of two
// so the read/write pointers wrap naturally. Pushes into a full FIFO and pops
// from an empty FIFO are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == DEPTH_CNT);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage write on an accepted push.
  // NOTE: the data array is not reset; the pointers and count alone decide
  // which entries are valid, so clearing storage would only cost logic.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Next pointer and occupancy values; push and pop together leave count as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first. Bytes are queued in uart_tx_fifo
// and serialised back to back with no idle gap while the queue is non-empty.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last
// data bit and the stop bit (11-bit frames instead of 10).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 5_000_000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_BITS-1:0]   dataIn,
  input  logic                   dataReady,
  output logic                   ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t            state_q;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 overflow_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                 bit_done;
  logic                 pop;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (dataReady),
    .push_data_i (dataIn),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  // Pop the queue head when idle, or at the end of a stop bit to chain frames.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bit_done = (baud_cnt_q == CNT_LAST);
    pop      = 1'b0;
    case (state_q)
      IDLE:    pop = !fifo_empty;
      STOP:    pop = bit_done && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Frame sequencer: state, bit timer, bit index, shift register and tx line.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          tx_q       <= 1'b1;
          if (pop) begin
            shift_q <= fifo_data;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            state_q    <= DATA;
            tx_q       <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            state_q    <= STOP;
            tx_q       <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q <= fifo_data;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          baud_cnt_q <= '0;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte being loaded, captured alongside the shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= ^fifo_data;
    end
  end
`endif

  // Sticky overflow flag: a write strobe while the queue is full.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (dataReady && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign ready      = !fifo_full;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = fifo_cnt;
  assign overflow   = overflow_q;

endmodule
